// File: rtl/seg_display_if.sv
// rtl/seg_display_if.sv - control and display bus of the hex 7-segment driver
interface seg_display_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lz_en;
  logic [7*NUM_DIGITS-1:0] seg;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg_scan;

  modport master (
    output value, load, digit_en, blink_mask, lz_en,
    input  seg, an, seg_scan
  );

  modport slave (
    input  value, load, digit_en, blink_mask, lz_en,
    output seg, an, seg_scan
  );
endinterface

// File: rtl/seg_display_driver.sv
// rtl/seg_display_driver.sv - N-digit hex 7-segment driver with static and scanned outputs
module seg_display_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25000,
  parameter int SCAN_DIV   = 1000
) (
  input  logic         clk,
  input  logic         rst,
  seg_display_if.slave bus
);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_off;
  logic [SW-1:0]           scan_cnt;
  logic [IW-1:0]           scan_idx;
  logic [6:0]              seg_q [NUM_DIGITS];
  logic [6:0]              seg_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_scan_q;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    zero_run;
  logic                    blank;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h01;
      4'h1: decode = 7'h4F;
      4'h2: decode = 7'h12;
      4'h3: decode = 7'h06;
      4'h4: decode = 7'h4C;
      4'h5: decode = 7'h24;
      4'h6: decode = 7'h20;
      4'h7: decode = 7'h0F;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h04;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h60;
      4'hC: decode = 7'h31;
      4'hD: decode = 7'h42;
      4'hE: decode = 7'h30;
      default: decode = 7'h38;
    endcase
  endfunction

  // zero_from[i]: every nibble from i up to the top digit is zero
  always_comb begin
    zero_from = '0;
    zero_run  = 1'b1;
    blank     = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (value_q[4*i +: 4] == 4'h0);
      zero_from[i] = zero_run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      blank    = ~bus.digit_en[i]
               | (blink_off & bus.blink_mask[i])
               | (bus.lz_en & (i != 0) & zero_from[i]);
      seg_d[i] = blank ? 7'h7F : decode(value_q[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      value_q    <= '0;
      blink_cnt  <= '0;
      blink_off  <= 1'b0;
      scan_cnt   <= '0;
      scan_idx   <= '0;
      an_q       <= '1;
      seg_scan_q <= 7'h7F;
      for (int i = 0; i < NUM_DIGITS; i++) seg_q[i] <= 7'h7F;
    end else begin
      if (bus.load) value_q <= bus.value;

      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      // anode and scanned segments come from the same index so they switch together
      an_q       <= ~(NUM_DIGITS'(1) << scan_idx);
      seg_scan_q <= seg_q[scan_idx];
      seg_q      <= seg_d;
    end
  end

  always_comb begin
    bus.seg = '1;
    for (int i = 0; i < NUM_DIGITS; i++) bus.seg[7*i +: 7] = seg_q[i];
  end

  assign bus.an       = an_q;
  assign bus.seg_scan = seg_scan_q;
endmodule

// File: tb/tb_seg_display_driver.sv
// tb/tb_seg_display_driver.sv - directed self-checking bench for seg_display_driver
module tb_seg_display_driver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  seg_display_if #(.NUM_DIGITS(8)) b8 ();
  seg_display_if #(.NUM_DIGITS(3)) b3 ();

  seg_display_driver #(.NUM_DIGITS(8), .BLINK_DIV(4), .SCAN_DIV(3)) dut8 (
    .clk(clk), .rst(rst), .bus(b8)
  );
  seg_display_driver #(.NUM_DIGITS(3), .BLINK_DIV(4), .SCAN_DIV(2)) dut3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [55:0] obs, input logic [55:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] dig(input int i);
    return b8.seg[7*i +: 7];
  endfunction

  logic [6:0] prev, cur, other;
  logic [2:0] prev_an;
  logic       found;
  logic [2:0] an_seq  [6];
  logic [6:0] scn_seq [6];

  initial begin
    b8.value = '0; b8.load = 1'b0; b8.digit_en = '1; b8.blink_mask = '0; b8.lz_en = 1'b0;
    b3.value = 12'h3A5; b3.load = 1'b1; b3.digit_en = '1; b3.blink_mask = '0; b3.lz_en = 1'b0;
    step(); step();
    check("reset_seg", b8.seg, {8{7'h7F}});
    check("reset_an", b8.an, 8'hFF);
    check("reset_seg_scan", b8.seg_scan, 7'h7F);
    check("reset_an3", b3.an, 3'b111);

    rst = 1'b1;
    step();
    b3.load = 1'b0;
    check("idle_zero", b8.seg, {8{7'h01}});

    // latency: old digits after the load edge, new ones one edge later
    b8.value = 32'h0123_89AB; b8.load = 1'b1;
    step();
    b8.load = 1'b0;
    check("t1_latency", b8.seg, {8{7'h01}});
    step();
    check("t1_digits", b8.seg, {7'h01, 7'h4F, 7'h12, 7'h06, 7'h00, 7'h04, 7'h08, 7'h60});

    b8.value = 32'hFEDC_BA98; b8.load = 1'b1;
    step();
    b8.load = 1'b0; b8.value = 32'h0;
    step();
    check("t2_digits", b8.seg, {7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00});

    b8.digit_en = 8'hFE;
    step();
    check("digit_en0", b8.seg, {7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h7F});
    b8.digit_en = '1;

    b8.lz_en = 1'b1; b8.value = 32'h0000_00A0; b8.load = 1'b1;
    step();
    b8.load = 1'b0;
    step();
    check("t3_lz_a0", b8.seg, {{6{7'h7F}}, 7'h08, 7'h01});
    b8.value = 32'h0; b8.load = 1'b1;
    step();
    b8.load = 1'b0;
    step();
    check("t3_lz_zero", b8.seg, {{7{7'h7F}}, 7'h01});
    b8.lz_en = 1'b0;
    step();
    check("t3_lz_off", b8.seg, {8{7'h01}});

    b8.value = 32'h5; b8.load = 1'b1;
    step();
    b8.load = 1'b0; b8.blink_mask = 8'h01;
    step(); step();
    prev = dig(0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (dig(0) !== prev) found = 1'b1;
      else prev = dig(0);
    end
    check("t4_edge_found", found, 1'b1);
    cur = dig(0);
    check("t4_phase_value", (cur == 7'h24) || (cur == 7'h7F), 1'b1);
    other = (cur == 7'h24) ? 7'h7F : 7'h24;
    for (int k = 1; k < 4; k++) begin
      step();
      check("t4_hold", dig(0), cur);
      check("t4_others", b8.seg[55:7], {7{7'h01}});
    end
    step();
    check("t4_flip", dig(0), other);
    b8.blink_mask = '0;

    // 3-digit scan: wait for the anode to move onto digit 0, then follow one full round
    an_seq  = '{3'b110, 3'b101, 3'b101, 3'b011, 3'b011, 3'b110};
    scn_seq = '{7'h24, 7'h08, 7'h08, 7'h06, 7'h06, 7'h24};
    prev_an = b3.an;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      step();
      if (b3.an === 3'b110 && prev_an !== 3'b110) found = 1'b1;
      else prev_an = b3.an;
    end
    check("t5_sync", found, 1'b1);
    check("t5_seg_scan_first", b3.seg_scan, 7'h24);
    for (int k = 0; k < 6; k++) begin
      step();
      check("t5_an", b3.an, an_seq[k]);
      check("t5_seg_scan", b3.seg_scan, scn_seq[k]);
    end

    b8.value = 32'hFFFF_FFFF; b8.load = 1'b1; b8.blink_mask = 8'h01;
    rst = 1'b0;
    step();
    check("t6_seg", b8.seg, {8{7'h7F}});
    check("t6_an", b8.an, 8'hFF);
    check("t6_seg_scan", b8.seg_scan, 7'h7F);
    check("t6_an3", b3.an, 3'b111);
    rst = 1'b1; b8.load = 1'b0;
    step();
    check("t6_relight", b8.seg, {8{7'h01}});
    check("t6_an_e1", b8.an, 8'hFE);
    check("t6_scan_e1", b8.seg_scan, 7'h7F);
    check("t6_an3_e1", b3.an, 3'b110);
    step();
    check("t6_an_e2", b8.an, 8'hFE);
    check("t6_scan_e2", b8.seg_scan, 7'h01);
    step();
    check("t6_an_e3", b8.an, 8'hFE);
    check("t6_an3_e3", b3.an, 3'b101);
    step();
    check("t6_an_e4", b8.an, 8'hFD);
    check("t6_scan_e4", b8.seg_scan, 7'h01);
    check("t6_blink_on", dig(0), 7'h01);
    step();
    check("t6_blink_off", dig(0), 7'h7F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
